// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle control sequencer for the 32-bit datapath (CTRL_STEP_EN: single-step fetch gating)
module mc_control_fsm #(
   parameter logic [4:0] ALU_ADD = 5'd0,
   parameter logic [4:0] ALU_SUB = 5'd1,
   parameter logic [4:0] ALU_AND = 5'd2,
   parameter logic [4:0] ALU_OR  = 5'd3
) (
   input  logic        clk,
   input  logic        reset_all,
   input  logic        start,
`ifdef CTRL_STEP_EN
   input  logic        step,
`endif
   input  logic [31:0] out_ins,
   input  logic [2:0]  comp_res,
   output logic        en,
   output logic        read,
   output logic        write,
   output logic        writeport,
   output logic        writedata,
   output logic        src1,
   output logic        src2,
   output logic        ld_lmd,
   output logic        en_data_mem,
   output logic        wri_data_mem,
   output logic        en_ins_mem,
   output logic        selcomp,
   output logic        selPC,
   output logic        ld_pc,
   output logic        resetPC,
   output logic        load_ir,
   output logic        isbranch,
   output logic [4:0]  alu_func,
   output logic [1:0]  selsig,
   output logic        busy,
   output logic        halted,
   output logic        illegal,
   output logic [15:0] instr_count
);

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_ADDI = 5'b00001;
   localparam logic [4:0] OP_SUBI = 5'b00010;
   localparam logic [4:0] OP_ANDI = 5'b00011;
   localparam logic [4:0] OP_ORI  = 5'b00100;
   localparam logic [4:0] OP_LD   = 5'b00101;
   localparam logic [4:0] OP_ST   = 5'b00110;
   localparam logic [4:0] OP_BEQ  = 5'b01000;
   localparam logic [4:0] OP_BLT  = 5'b01001;
   localparam logic [4:0] OP_BGT  = 5'b01010;
   localparam logic [4:0] OP_BZ   = 5'b01011;
   localparam logic [4:0] OP_JMP  = 5'b01100;
   localparam logic [4:0] OP_JAL  = 5'b01101;
   localparam logic [4:0] OP_HALT = 5'b11111;

   typedef enum logic [3:0] {
      S_IDLE, S_IF, S_IR, S_ID, S_EX, S_MEM, S_LMD, S_WB, S_HALTED
   } state_t;

   state_t     state, state_next;
   logic [4:0] opcode;
   logic [4:0] func;
   logic       is_rtype, is_imm, is_ld, is_st, is_cond, is_jmp, is_jal, is_halt, is_undef;
   logic [4:0] imm_alu;

   // The comparator flags are consumed by the datapath PC mux through selsig; the
   // register/immediate fields of the instruction are likewise datapath-only.
   logic unused_inputs;
   assign unused_inputs = ^{out_ins[26:5], comp_res};

   assign opcode   = out_ins[31:27];
   assign func     = out_ins[4:0];
   assign is_rtype = (opcode == OP_R);
   assign is_imm   = (opcode == OP_ADDI) || (opcode == OP_SUBI) || (opcode == OP_ANDI) || (opcode == OP_ORI);
   assign is_ld    = (opcode == OP_LD);
   assign is_st    = (opcode == OP_ST);
   assign is_cond  = (opcode == OP_BEQ) || (opcode == OP_BLT) || (opcode == OP_BGT) || (opcode == OP_BZ);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_jal   = (opcode == OP_JAL);
   assign is_halt  = (opcode == OP_HALT);
   assign is_undef = !(is_rtype || is_imm || is_ld || is_st || is_cond || is_jmp || is_jal || is_halt);
   assign imm_alu  = (opcode == OP_SUBI) ? ALU_SUB :
                     (opcode == OP_ANDI) ? ALU_AND :
                     (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;

   // State register
   always_ff @(posedge clk) begin
      if (reset_all) state <= S_IDLE;
      else           state <= state_next;
   end

   // Retired-instruction counter and sticky undefined-opcode flag
   always_ff @(posedge clk) begin
      if (reset_all) begin
         instr_count <= 16'd0;
         illegal     <= 1'b0;
      end else begin
         if (ld_pc) instr_count <= instr_count + 16'd1;
         if (state == S_EX && is_undef) illegal <= 1'b1;
      end
   end

   // Next-state and Moore strobe decode from state plus opcode; reset overrides last
   always_comb begin
      state_next   = state;
      en           = 1'b0;
      read         = 1'b0;
      write        = 1'b0;
      writeport    = 1'b0;
      writedata    = 1'b0;
      src1         = 1'b0;
      src2         = 1'b0;
      ld_lmd       = 1'b0;
      en_data_mem  = 1'b0;
      wri_data_mem = 1'b0;
      en_ins_mem   = 1'b0;
      selcomp      = 1'b0;
      selPC        = 1'b0;
      ld_pc        = 1'b0;
      resetPC      = 1'b0;
      load_ir      = 1'b0;
      isbranch     = 1'b0;
      alu_func     = ALU_ADD;
      selsig       = 2'd0;
      busy         = (state != S_IDLE) && (state != S_HALTED);
      halted       = (state == S_HALTED);
      case (state)
         S_IDLE: begin
            resetPC = 1'b1;
            if (start) state_next = S_IF;
         end
         S_IF: begin
            en = 1'b1;
`ifdef CTRL_STEP_EN
            en_ins_mem = step;
            state_next = step ? S_IR : S_IF;
`else
            en_ins_mem = 1'b1;
            state_next = S_IR;
`endif
         end
         S_IR: begin
            en         = 1'b1;
            load_ir    = 1'b1;
            state_next = S_ID;
         end
         S_ID: begin
            en         = 1'b1;
            read       = 1'b1;
            state_next = is_halt ? S_HALTED : S_EX;
         end
         S_EX, S_MEM, S_LMD, S_WB: begin
            en   = 1'b1;
            read = 1'b1;
            // EX controls are held through MEM/LMD/WB so Z stays valid
            if (is_rtype) begin
               src1 = 1'b1; src2 = 1'b1; alu_func = func;
            end else if (is_imm) begin
               src1 = 1'b1; alu_func = imm_alu;
            end else if (is_ld || is_st) begin
               src1 = 1'b1;
            end else if (is_cond) begin
               selcomp = (opcode == OP_BZ);
               selsig  = (opcode == OP_BLT) ? 2'd1 : (opcode == OP_BGT) ? 2'd3 : 2'd2;
            end else if (is_jmp || is_jal) begin
               selPC = 1'b1;
            end
            case (state)
               S_EX: begin
                  if (is_cond || is_jmp || is_jal || is_undef) begin
                     ld_pc      = 1'b1;
                     isbranch   = is_jal;
                     write      = is_jal;
                     state_next = S_IF;
                  end else if (is_ld || is_st) begin
                     state_next = S_MEM;
                  end else begin
                     state_next = S_WB;
                  end
               end
               S_MEM: begin
                  en_data_mem = 1'b1;
                  if (is_st) begin
                     wri_data_mem = 1'b1;
                     ld_pc        = 1'b1;
                     state_next   = S_IF;
                  end else begin
                     state_next = S_LMD;
                  end
               end
               S_LMD: begin
                  ld_lmd     = 1'b1;
                  state_next = S_WB;
               end
               default: begin
                  write      = 1'b1;
                  writedata  = !is_ld;
                  writeport  = is_rtype;
                  ld_pc      = 1'b1;
                  state_next = S_IF;
               end
            endcase
         end
         S_HALTED: begin
            en = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase
      if (reset_all) begin
         en           = 1'b0;
         read         = 1'b0;
         write        = 1'b0;
         writeport    = 1'b0;
         writedata    = 1'b0;
         src1         = 1'b0;
         src2         = 1'b0;
         ld_lmd       = 1'b0;
         en_data_mem  = 1'b0;
         wri_data_mem = 1'b0;
         en_ins_mem   = 1'b0;
         selcomp      = 1'b0;
         selPC        = 1'b0;
         ld_pc        = 1'b0;
         load_ir      = 1'b0;
         isbranch     = 1'b0;
         alu_func     = 5'd0;
         selsig       = 2'd0;
         busy         = 1'b0;
         halted       = 1'b0;
         resetPC      = 1'b1;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench: strobe-driven datapath model plus ISA-level reference for mc_control_fsm
module tb_mc_control_fsm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_all, start;
   logic [31:0] out_ins;
   logic [2:0]  comp_res;
   logic en, read, write, writeport, writedata, src1, src2, ld_lmd;
   logic en_data_mem, wri_data_mem, en_ins_mem, selcomp, selPC, ld_pc, resetPC, load_ir, isbranch;
   logic [4:0]  alu_func;
   logic [1:0]  selsig;
   logic        busy, halted, illegal;
   logic [15:0] instr_count;
   logic [16:0] strobes;

   mc_control_fsm dut (
      .clk(clk), .reset_all(reset_all), .start(start), .out_ins(out_ins), .comp_res(comp_res),
      .en(en), .read(read), .write(write), .writeport(writeport), .writedata(writedata),
      .src1(src1), .src2(src2), .ld_lmd(ld_lmd), .en_data_mem(en_data_mem),
      .wri_data_mem(wri_data_mem), .en_ins_mem(en_ins_mem), .selcomp(selcomp), .selPC(selPC),
      .ld_pc(ld_pc), .resetPC(resetPC), .load_ir(load_ir), .isbranch(isbranch),
      .alu_func(alu_func), .selsig(selsig), .busy(busy), .halted(halted), .illegal(illegal),
      .instr_count(instr_count)
   );

   assign strobes = {en, read, write, writeport, writedata, src1, src2, ld_lmd, en_data_mem,
                     wri_data_mem, en_ins_mem, selcomp, selPC, ld_pc, resetPC, load_ir, isbranch};

   localparam logic [31:0] HALT_INS = 32'hF800_0000;

   // ---------------- datapath model driven by the DUT strobes ----------------
   logic [31:0] regs [16];
   logic [31:0] dmem [64];
   logic [31:0] init_regs [16];
   logic [31:0] init_mem [64];
   logic        load_env;
   logic [31:0] pc, npc, fetch, ir, a_reg, b_reg, lmd;
   logic [31:0] opa, opb, z, se, comp_b;
   logic        pc_take;
   logic [31:0] fetch_q [$];

   assign out_ins = ir;

   always_comb begin
      se      = {{17{ir[14]}}, ir[14:0]};
      opa     = src1 ? a_reg : npc;
      opb     = src2 ? b_reg : se;
      case (alu_func)
         5'd0:    z = opa + opb;
         5'd1:    z = opa - opb;
         5'd2:    z = opa & opb;
         5'd3:    z = opa | opb;
         default: z = 32'd0;
      endcase
      comp_b   = selcomp ? 32'd0 : b_reg;
      comp_res = {$signed(a_reg) > $signed(comp_b), a_reg == comp_b, $signed(a_reg) < $signed(comp_b)};
      case (selsig)
         2'd0:    pc_take = selPC;
         2'd1:    pc_take = comp_res[0];
         2'd2:    pc_take = comp_res[1];
         default: pc_take = comp_res[2];
      endcase
   end

   always @(posedge clk) begin
      if (load_env) begin
         regs <= init_regs;
         dmem <= init_mem;
         ir   <= 32'd0;
      end
      if (resetPC) pc <= 32'd0;
      if (en_ins_mem) begin
         if (fetch_q.size() > 0) fetch <= fetch_q.pop_front();
         else                    fetch <= HALT_INS;
         npc <= pc + 32'd1;
      end
      if (load_ir) ir <= fetch;
      if (read) begin
         a_reg <= regs[ir[26:23]];
         b_reg <= regs[ir[22:19]];
      end
      if (write)
         regs[isbranch ? 4'd15 : (writeport ? ir[18:15] : ir[22:19])] <= isbranch ? npc : (writedata ? z : lmd);
      if (ld_lmd) lmd <= dmem[z[5:0]];
      if (en_data_mem && wri_data_mem) dmem[z[5:0]] <= b_reg;
      if (ld_pc) pc <= pc_take ? z : npc;
   end

   // ---------------- ISA-level reference model and scoreboard ----------------
   typedef struct packed {
      logic [31:0] pc;
      logic        has_wr;
      logic [3:0]  wr_idx;
      logic [31:0] wr_val;
      logic        has_mw;
      logic [5:0]  mw_addr;
      logic [31:0] mw_val;
      logic [15:0] count;
      logic        ill;
      logic [3:0]  lat;
      logic [4:0]  op;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] m_regs [16];
   logic [31:0] m_mem [64];
   logic [31:0] m_pc;
   logic [15:0] m_count;
   logic        m_ill;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] rs, input logic [3:0] rt,
                                       input logic [3:0] rd, input logic [14:0] imm);
      return {op, rs, rt, rd, imm};
   endfunction

   task automatic issue(input logic [31:0] ins);
      exp_t        e;
      logic [4:0]  op;
      logic [31:0] a, b, sx, val;
      logic [5:0]  addr;
      logic        take;
      op   = ins[31:27];
      a    = m_regs[ins[26:23]];
      b    = m_regs[ins[22:19]];
      sx   = {{17{ins[14]}}, ins[14:0]};
      addr = 6'(a + sx);
      e    = '0;
      e.op = op;
      take = 1'b0;
      val  = 32'd0;
      m_count = m_count + 16'd1;
      e.lat = 4'd5;
      case (op)
         5'd0: begin
            case (ins[1:0])
               2'd0: val = a + b;
               2'd1: val = a - b;
               2'd2: val = a & b;
               default: val = a | b;
            endcase
            e.has_wr = 1'b1; e.wr_idx = ins[18:15];
         end
         5'd1: begin val = a + sx; e.has_wr = 1'b1; e.wr_idx = ins[22:19]; end
         5'd2: begin val = a - sx; e.has_wr = 1'b1; e.wr_idx = ins[22:19]; end
         5'd3: begin val = a & sx; e.has_wr = 1'b1; e.wr_idx = ins[22:19]; end
         5'd4: begin val = a | sx; e.has_wr = 1'b1; e.wr_idx = ins[22:19]; end
         5'd5: begin val = m_mem[addr]; e.has_wr = 1'b1; e.wr_idx = ins[22:19]; e.lat = 4'd7; end
         5'd6: begin m_mem[addr] = b; e.has_mw = 1'b1; e.mw_addr = addr; e.mw_val = b; end
         5'd8:  begin take = (a == b); e.lat = 4'd4; end
         5'd9:  begin take = ($signed(a) < $signed(b)); e.lat = 4'd4; end
         5'd10: begin take = ($signed(a) > $signed(b)); e.lat = 4'd4; end
         5'd11: begin take = (a == 32'd0); e.lat = 4'd4; end
         5'd12: begin take = 1'b1; e.lat = 4'd4; end
         5'd13: begin take = 1'b1; val = m_pc + 32'd1; e.has_wr = 1'b1; e.wr_idx = 4'd15; e.lat = 4'd4; end
         default: begin m_ill = 1'b1; e.lat = 4'd4; end
      endcase
      if (e.has_wr) begin
         m_regs[e.wr_idx] = val;
         e.wr_val = val;
      end
      m_pc    = take ? (m_pc + 32'd1 + sx) : (m_pc + 32'd1);
      e.pc    = m_pc;
      e.count = m_count;
      e.ill   = m_ill;
      exp_q.push_back(e);
      fetch_q.push_back(ins);
   endtask

   function automatic logic [31:0] rand_ins();
      logic [31:0] r;
      logic [4:0]  op;
      logic [14:0] imm;
      r = $urandom;
      case (r[3:0])
         4'd0, 4'd1: op = 5'd0;
         4'd2:       op = 5'd1;
         4'd3:       op = 5'd2;
         4'd4:       op = 5'd3;
         4'd5:       op = 5'd4;
         4'd6, 4'd7: op = 5'd5;
         4'd8, 4'd9: op = 5'd6;
         4'd10:      op = 5'd8;
         4'd11:      op = 5'd9;
         4'd12:      op = 5'd10;
         4'd13:      op = 5'd11;
         4'd14:      op = r[4] ? 5'd12 : 5'd13;
         default:    op = r[5] ? 5'd7 : (5'd16 + {2'b00, r[8:6]});
      endcase
      imm = (op == 5'd0) ? {13'd0, r[15:14]} : {{11{r[13]}}, r[13:10]};
      return enc(op, r[19:16], r[23:20], r[27:24], imm);
   endfunction

   // Monitor: after each retire cycle, pop the expected effect and compare committed state
   int   cyc = 0;
   int   if_cyc = 0;
   int   ret_lat = 0;
   logic pending = 1'b0;
   initial begin
      exp_t cur;
      forever begin
         @(negedge clk);
         cyc++;
         if (pending) begin
            pending = 1'b0;
            check("retire_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               cur = exp_q.pop_front();
               check($sformatf("pc_op%0d", cur.op), pc, cur.pc);
               check($sformatf("instr_count_op%0d", cur.op), 32'(instr_count), 32'(cur.count));
               check($sformatf("illegal_op%0d", cur.op), 32'(illegal), 32'(cur.ill));
               check($sformatf("latency_op%0d", cur.op), ret_lat, 32'(cur.lat));
               if (cur.has_wr) check($sformatf("reg_write_op%0d", cur.op), regs[cur.wr_idx], cur.wr_val);
               if (cur.has_mw) check($sformatf("mem_write_op%0d", cur.op), dmem[cur.mw_addr], cur.mw_val);
            end
         end
         if (en_ins_mem) if_cyc = cyc;
         if (ld_pc) begin
            pending = 1'b1;
            ret_lat = cyc - if_cyc + 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic init_default();
      for (int i = 0; i < 16; i++) init_regs[i] = 32'd0;
      for (int i = 0; i < 64; i++) init_mem[i] = 32'h1000 + 32'(i);
   endtask

   task automatic do_reset();
      fetch_q.delete();
      exp_q.delete();
      m_regs  = init_regs;
      m_mem   = init_mem;
      m_pc    = 32'd0;
      m_count = 16'd0;
      m_ill   = 1'b0;
      @(posedge clk);
      #1 reset_all = 1'b1; load_env = 1'b1; start = 1'b0;
      repeat (2) begin
         @(negedge clk);
         check("reset_strobes", 32'(strobes), 32'h4);
         check("reset_status", 32'({busy, halted}), 32'd0);
         @(posedge clk);
      end
      #1 reset_all = 1'b0; load_env = 1'b0;
      @(negedge clk);
      check("idle_strobes", 32'(strobes), 32'h4);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_count", 32'(instr_count), 32'd0);
      check("idle_flags", 32'({illegal, halted}), 32'd0);
   endtask

   task automatic kick(input int hold);
      @(posedge clk);
      #1 start = 1'b1;
      @(negedge clk);
      check("no_fetch_in_idle", 32'(en_ins_mem), 32'd0);
      @(posedge clk);
      @(negedge clk);
      check("fetch_after_start", 32'(en_ins_mem), 32'd1);
      check("busy_in_if", 32'(busy), 32'd1);
      repeat (hold - 1) @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_halt();
      for (int i = 0; i < 3000 && halted !== 1'b1; i++) @(negedge clk);
      check("halted_reached", 32'(halted), 32'd1);
      check("scoreboard_drained", exp_q.size(), 32'd0);
   endtask

   initial begin
      reset_all = 1'b1;
      start     = 1'b0;
      load_env  = 1'b0;

      // ADD, LD, taken BEQ
      init_default();
      init_regs[1] = 32'd5; init_regs[2] = 32'd7; init_regs[5] = 32'd9; init_mem[9] = 32'hDEAD;
      do_reset();
      issue(enc(5'd0, 4'd1, 4'd2, 4'd3, 15'd0));
      issue(enc(5'd5, 4'd5, 4'd4, 4'd0, 15'd0));
      issue(enc(5'd8, 4'd1, 4'd1, 4'd0, 15'd3));
      kick(1);
      wait_halt();
      check("add_r3", regs[3], 32'd12);
      check("ld_r4", regs[4], 32'hDEAD);
      check("beq_taken_pc", pc, 32'd6);
      check("count_3", 32'(instr_count), 32'd3);

      // same program, BEQ not taken; start held several cycles
      do_reset();
      issue(enc(5'd0, 4'd1, 4'd2, 4'd3, 15'd0));
      issue(enc(5'd5, 4'd5, 4'd4, 4'd0, 15'd0));
      issue(enc(5'd8, 4'd1, 4'd2, 4'd0, 15'd3));
      kick(3);
      wait_halt();
      check("beq_not_taken_pc", pc, 32'd3);

      // JAL at PC 0
      init_default();
      do_reset();
      issue(enc(5'd13, 4'd0, 4'd0, 4'd0, 15'd4));
      kick(1);
      wait_halt();
      check("jal_r15", regs[15], 32'd1);
      check("jal_pc", pc, 32'd5);

      // randomized program, then opcode 10000, then HALT
      for (int i = 0; i < 16; i++) init_regs[i] = 32'($urandom_range(0, 7));
      for (int i = 0; i < 64; i++) init_mem[i] = $urandom;
      do_reset();
      for (int i = 0; i < 40; i++) issue(rand_ins());
      issue(enc(5'd16, 4'd0, 4'd0, 4'd0, 15'd0));
      kick(1);
      wait_halt();
      check("halt_strobes", 32'(strobes), 32'h10000);
      check("halt_alu_sel", 32'({alu_func, selsig}), 32'd0);
      check("halt_busy", 32'(busy), 32'd0);
      check("halt_illegal", 32'(illegal), 32'd1);
      @(posedge clk);
      #1 start = 1'b1;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      check("halt_ignores_start", 32'(halted), 32'd1);
      check("halt_strobes_after_start", 32'(strobes), 32'h10000);
      check("halt_count_frozen", 32'(instr_count), 32'(m_count));
      check("halt_illegal_sticky", 32'(illegal), 32'd1);
      @(posedge clk);
      #1 reset_all = 1'b1;
      @(negedge clk);
      check("halt_reset_strobes", 32'(strobes), 32'h4);
      @(posedge clk);
      #1 reset_all = 1'b0;
      @(negedge clk);
      check("reset_clears_illegal", 32'(illegal), 32'd0);
      check("reset_clears_halted", 32'(halted), 32'd0);
      check("reset_clears_count", 32'(instr_count), 32'd0);

      // reset during EX of an ADD abandons it
      init_default();
      init_regs[1] = 32'd5; init_regs[2] = 32'd7;
      do_reset();
      fetch_q.push_back(enc(5'd0, 4'd1, 4'd2, 4'd3, 15'd0));
      kick(1);
      repeat (3) @(negedge clk);
      reset_all = 1'b1;
      @(posedge clk);
      #1 reset_all = 1'b0;
      @(negedge clk);
      check("abandon_no_write", regs[3], 32'd0);
      check("abandon_no_count", 32'(instr_count), 32'd0);
      check("abandon_pc", pc, 32'd0);
      check("abandon_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, checks %0d passed of %0d", n_pass, n_checks);
      $fatal(1);
   end

endmodule
